// File: rtl/multi_pwm.sv
// Multi-channel PWM generator with per-channel shadow/active duty registers.
// A free-running base counter drives all channels; a written duty is held in a
// shadow register and applied to the active register at the channel's wrap
// (or on the next edge while the block is disabled).
// Optional build macro: PWM_PHASE_STAGGER_EN spreads the channels' period
// starts evenly across the base period. Without it every channel is
// edge-aligned to the base counter.
module multi_pwm #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 2,
  localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ChW-1:0]    wr_ch,
  input  logic [WIDTH-1:0]  wr_duty,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pending,
  output logic              period_start
);

  // Phase distance between neighbouring channels when staggering is enabled.
  localparam int unsigned Step = (32'd1 << WIDTH) / NUM_CH;

`ifdef PWM_PHASE_STAGGER_EN
  localparam bit Stagger = 1'b1;
`else
  localparam bit Stagger = 1'b0;
`endif

  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  shadow_q [NUM_CH];
  logic [WIDTH-1:0]  shadow_d [NUM_CH];
  logic [WIDTH-1:0]  active_q [NUM_CH];
  logic [WIDTH-1:0]  active_d [NUM_CH];
  logic [WIDTH-1:0]  ecnt     [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              ps_q, ps_d;
  logic              wr_valid;

  // Writes addressed beyond the last channel are dropped.
  assign wr_valid = wr_en && (32'(wr_ch) < NUM_CH);

  // Per-channel effective count, phase-shifted only in the staggered build.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ecnt[i] = Stagger ? cnt_q + WIDTH'(32'(i) * Step) : cnt_q;
    end
  end

  // Next-state: base counter, period pulse, duty transfer and PWM compare.
  always_comb begin
    logic apply;
    logic hit;
    apply    = 1'b0;
    hit      = 1'b0;
    cnt_d    = en ? cnt_q + WIDTH'(1) : '0;
    ps_d     = en && (cnt_q == '0);
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    pwm_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Running: transfer at this channel's wrap. Stopped: transfer whenever pending.
      apply    = en ? (ecnt[i] == '1) : pend_q[i];
      hit      = wr_valid && (32'(wr_ch) == 32'(i));
      // Compare uses the pre-transfer active duty so the wrap cycle stays glitch-free.
      pwm_d[i] = en && (ecnt[i] < active_q[i]);
      // Active takes the old shadow even if a write lands in the same cycle.
      if (apply) begin
        active_d[i] = shadow_q[i];
      end
      if (hit) begin
        shadow_d[i] = wr_duty;
      end
      pend_d[i] = hit | (pend_q[i] & ~apply);
    end
  end

  // State registers; reset dominates enable and writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      pend_q   <= '0;
      pwm_q    <= '0;
      ps_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pwm_q    <= pwm_d;
      ps_q     <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign pending      = pend_q;
  assign period_start = ps_q;

endmodule
